// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one sram-like memory port between the i-cache and the d-cache.
//   Only one transaction is outstanding at a time. The d-cache normally
//   wins arbitration. A starvation counter forces an i-cache grant after
//   STARVE_MAX consecutive data grants made while the i-cache was waiting.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   inst_* (req/wr/size/addr/wdata in; rdata/addr_ok/data_ok out)
//                             i-cache request side
//   data_* (req/wr/size/addr/wdata in; rdata/addr_ok/data_ok out)
//                             d-cache request side
//   mem_*  (req/wr/size/addr/wdata out; rdata/addr_ok/data_ok in)
//                             shared memory / bridge side
//
// A transaction takes at least three cycles at zero memory latency:
// one arbitration cycle in IDLE, the address phase, and the data phase.

module cache_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int STARVE_W   = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state;
  logic                owner;       // 0 = i-cache, 1 = d-cache
  logic [STARVE_W-1:0] starve_cnt;

  logic starved;
  logic grant_data;
  logic accept;

  // The i-cache is forced through only when it is actually waiting and
  // the d-cache has already won STARVE_MAX times in a row against it.
  assign starved    = (starve_cnt == STARVE_LIM);
  assign grant_data = data_req & ~(inst_req & starved);

  // Request is forwarded live from the owner so that an owner dropping its
  // request before acceptance simply withdraws it from memory.
  assign mem_req   = (state == ADDR) & (owner ? data_req : inst_req);
  assign mem_wr    = owner ? data_wr    : inst_wr;
  assign mem_size  = owner ? data_size  : inst_size;
  assign mem_addr  = owner ? data_addr  : inst_addr;
  assign mem_wdata = owner ? data_wdata : inst_wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & ~owner;
  assign data_addr_ok = accept &  owner;

  // Data-done is only meaningful in DATA; stray pulses from memory in the
  // other states (e.g. left over from an abandoned transaction) are dropped.
  assign inst_data_ok = (state == DATA) & ~owner & mem_data_ok;
  assign data_data_ok = (state == DATA) &  owner & mem_data_ok;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Arbitration, transaction phase tracking and starvation bookkeeping.
  // Reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req | data_req) begin
            owner <= grant_data;
            state <= ADDR;
            if (grant_data) begin
              if (inst_req && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ADDR: begin
          if (accept) begin
            state <= DATA;
          end else if (!mem_req) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Random traffic from two cache masters and a random-latency memory,
//   checked by a scoreboard against a transaction-level arbitration model,
//   followed by a few directed scenarios (writeback, reset mid-transaction,
//   simultaneous requests, request withdrawal).

module tb_cache_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;

  cache_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .STARVE_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  typedef struct {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } resp_t;

  grant_t exp_grant_q[$];
  resp_t  exp_resp_q[$];

  int checks = 0;
  int failures = 0;

  // Master bookkeeping, index 0 = i-cache, 1 = d-cache.
  // m_state: 0 idle, 1 requesting, 2 waiting for data.
  int          m_state[2] = '{0, 0};
  int          m_delay[2] = '{0, 0};
  logic        m_wr[2];
  logic [1:0]  m_size[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  bit          stop_new = 1'b0;

  // Memory model and arbitration reference model.
  int   mem_phase = 0;
  int   mem_lat = 0;
  bit   mem_resp_now = 1'b0;
  bit   model_free = 1'b1;
  int   model_starve = 0;
  logic model_owner = 1'b0;

  // Handshake observations taken just before each rising edge.
  bit   mon_en = 1'b1;
  bit   obs_hs = 1'b0;
  logic obs_aok[2] = '{1'b0, 1'b0};
  logic obs_dok[2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Drives both masters and the memory for the coming edge, and predicts
  // the grant whenever the arbiter is known to be free.
  task automatic applyStimulus();
    grant_t g;
    resp_t  r;
    logic   win;
    if (mem_resp_now) model_free = 1'b1;

    for (int m = 0; m < 2; m++) begin
      if (m_state[m] == 1 && obs_aok[m]) begin
        m_state[m] = 2;
      end else if (m_state[m] == 2 && obs_dok[m]) begin
        m_state[m] = 0;
        m_delay[m] = int'($urandom_range(0, 3));
        if (m_delay[m] < 2) m_delay[m] = 0;
      end else if (m_state[m] == 0 && m_delay[m] > 0) begin
        m_delay[m]--;
      end
      if (m_state[m] == 0 && m_delay[m] == 0 && !stop_new) begin
        m_wr[m]    = 1'($urandom_range(0, 1));
        m_size[m]  = 2'($urandom_range(0, 3));
        m_addr[m]  = $urandom & 32'hFFFF_FFFC;
        m_wdata[m] = $urandom;
        m_state[m] = 1;
      end
    end

    inst_req = (m_state[0] == 1);
    inst_wr = m_wr[0]; inst_size = m_size[0]; inst_addr = m_addr[0]; inst_wdata = m_wdata[0];
    data_req = (m_state[1] == 1);
    data_wr = m_wr[1]; data_size = m_size[1]; data_addr = m_addr[1]; data_wdata = m_wdata[1];

    if (model_free && (inst_req || data_req)) begin
      if (data_req && !(inst_req && model_starve == STARVE_MAX)) begin
        win = 1'b1;
        if (inst_req && model_starve < STARVE_MAX) model_starve++;
      end else begin
        win = 1'b0;
        model_starve = 0;
      end
      g.owner = win;
      g.wr    = m_wr[win];
      g.size  = m_size[win];
      g.addr  = m_addr[win];
      g.wdata = m_wdata[win];
      exp_grant_q.push_back(g);
      model_owner = win;
      model_free = 1'b0;
    end

    mem_resp_now = 1'b0;
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b0;
    if (mem_phase == 0 && obs_hs) begin
      mem_phase = 1;
      mem_lat = int'($urandom_range(0, 3));
    end
    if (mem_phase == 1) begin
      if (mem_lat == 0) begin
        mem_data_ok = 1'b1;
        mem_rdata = $urandom;
        mem_resp_now = 1'b1;
        r.owner = model_owner;
        r.rdata = mem_rdata;
        exp_resp_q.push_back(r);
        mem_phase = 0;
      end else begin
        mem_lat--;
      end
    end else begin
      mem_addr_ok = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) == 0) begin
        mem_data_ok = 1'b1;
        mem_rdata = $urandom;
      end
    end
  endtask

  // Scoreboard side: compares the DUT against queued expectations.
  task automatic checkOutput();
    grant_t g;
    resp_t  r;
    obs_hs = mem_req && mem_addr_ok;
    obs_aok[0] = inst_addr_ok;
    obs_aok[1] = data_addr_ok;
    obs_dok[0] = inst_data_ok;
    obs_dok[1] = data_data_ok;
    if (!rst) begin
      check("reset_mem_req", 32'(mem_req), 32'd0);
      check("reset_ok_flags", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    end else begin
      if (obs_hs) begin
        if (exp_grant_q.size() == 0) begin
          check("grant_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          g = exp_grant_q.pop_front();
          check("grant_owner", 32'({inst_addr_ok, data_addr_ok}), g.owner ? 32'd1 : 32'd2);
          check("grant_addr", mem_addr, g.addr);
          check("grant_wr", 32'(mem_wr), 32'(g.wr));
          check("grant_size", 32'(mem_size), 32'(g.size));
          check("grant_wdata", mem_wdata, g.wdata);
        end
      end else begin
        check("addr_ok_no_accept", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      end
      if (mem_resp_now) begin
        if (exp_resp_q.size() == 0) begin
          check("resp_unexpected", 32'({inst_data_ok, data_data_ok}), 32'hFFFF_FFFF);
        end else begin
          r = exp_resp_q.pop_front();
          check("data_ok_owner", 32'({inst_data_ok, data_data_ok}), r.owner ? 32'd1 : 32'd2);
          check("rdata", r.owner ? data_rdata : inst_rdata, r.rdata);
        end
      end else begin
        check("data_ok_spurious", 32'({inst_data_ok, data_data_ok}), 32'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) checkOutput();
    end
  end

  initial begin
    int guard;
    $display("[TB] reset with random inputs");
    repeat (4) begin
      @(negedge clk);
      inst_req = 1'($urandom); data_req = 1'($urandom);
      inst_wr = 1'($urandom); data_wr = 1'($urandom);
      inst_addr = $urandom; data_addr = $urandom;
      mem_addr_ok = 1'($urandom); mem_data_ok = 1'($urandom);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = 1'b1;
      applyStimulus();
    end

    stop_new = 1'b1;
    guard = 0;
    while ((m_state[0] != 0 || m_state[1] != 0 || mem_phase != 0) && guard < 300) begin
      @(negedge clk);
      applyStimulus();
      guard++;
    end
    check("drain_timeout", 32'(guard >= 300), 32'd0);
    check("grant_queue_left", 32'(exp_grant_q.size()), 32'd0);
    check("resp_queue_left", 32'(exp_resp_q.size()), 32'd0);

    $display("[TB] directed: writeback then reset during data phase");
    @(negedge clk);
    mon_en = 1'b0;
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_2000; data_wdata = 32'h1234_5678;
    #1 check("wb_bubble", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1 check("wb_mem_req", 32'(mem_req), 32'd1);
    check("wb_mem_wr", 32'(mem_wr), 32'd1);
    check("wb_mem_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    mem_addr_ok = 1'b1;
    #1 check("wb_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd1);
    check("wb_wdata_held", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    data_req = 1'b0; mem_addr_ok = 1'b0; rst = 1'b0;
    #1 check("wb_data_phase_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1 check("stale_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);

    $display("[TB] directed: i-cache read");
    @(negedge clk);
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1FC0_0000;
    #1 check("inst_bubble", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1 check("inst_mem_addr", mem_addr, 32'h1FC0_0000);
    mem_addr_ok = 1'b1;
    #1 check("inst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd2);
    @(negedge clk);
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    #1 check("inst_wait", 32'({inst_data_ok, data_data_ok}), 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1 check("inst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd2);
    check("inst_rdata", inst_rdata, 32'hDEAD_BEEF);

    $display("[TB] directed: simultaneous requests");
    @(negedge clk);
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0040;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000;
    @(negedge clk);
    #1 check("both_first_addr", mem_addr, 32'h8000_1000);
    mem_addr_ok = 1'b1;
    #1 check("both_first_owner", 32'({inst_addr_ok, data_addr_ok}), 32'd1);
    @(negedge clk);
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1 check("both_first_done", 32'({inst_data_ok, data_data_ok}), 32'd1);
    check("both_first_rdata", data_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1 check("both_gap", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1 check("both_second_addr", mem_addr, 32'h1FC0_0040);
    mem_addr_ok = 1'b1;
    #1 check("both_second_owner", 32'({inst_addr_ok, data_addr_ok}), 32'd2);
    @(negedge clk);
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1 check("both_second_done", 32'({inst_data_ok, data_data_ok}), 32'd2);

    $display("[TB] directed: request withdrawn before accept");
    @(negedge clk);
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0080;
    @(negedge clk);
    #1 check("withdraw_req_seen", 32'(mem_req), 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1 check("withdraw_req_gone", 32'(mem_req), 32'd0);
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h8000_3000;
    #1 check("withdraw_idle_bubble", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1 check("withdraw_next_addr", mem_addr, 32'h8000_3000);
    check("withdraw_next_req", 32'(mem_req), 32'd1);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1 check("withdraw_next_done", 32'({inst_data_ok, data_data_ok}), 32'd1);
    @(negedge clk);
    mem_data_ok = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
